// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit with posted-store buffer.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } lsu_state_e;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam int unsigned LS_LB  = 10;
  localparam int unsigned LS_LBU = 9;
  localparam int unsigned LS_LD  = 8;
  localparam int unsigned LS_LH  = 7;
  localparam int unsigned LS_LHU = 6;
  localparam int unsigned LS_LW  = 5;
  localparam int unsigned LS_LWU = 4;
  localparam int unsigned LS_SB  = 3;
  localparam int unsigned LS_SD  = 2;
  localparam int unsigned LS_SH  = 1;
  localparam int unsigned LS_SW  = 0;

  // Entry is sized for the widest configuration; narrower builds use the low bits.
  localparam int unsigned MAX_AW   = 64;
  localparam int unsigned MAX_XLEN = 64;
  localparam int unsigned MAX_NB   = MAX_XLEN / 8;

  typedef struct packed {
    logic [MAX_AW-1:0]   addr;
    logic [MAX_XLEN-1:0] wdata;
    logic [MAX_NB-1:0]   wstrb;
    logic [2:0]          size;
  } sb_entry_t;

  function automatic logic [7:0] size_mask(input logic [2:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_fifo.sv
// Circular store buffer: push at tail, pop at head, count-based full/empty.
module lsu_store_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          push_ok, pop_ok;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lsu_sbuf.sv
// MEM-stage load/store unit: posted-store buffer draining to a valid/ready RAM port,
// loads ordered behind buffered stores, lane alignment and misalignment detection.
module lsu_sbuf
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned AW       = 64,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_mem_addr,
  input  logic [XLEN-1:0]   i_mem_wdata,
  input  logic [10:0]       i_ls_info,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  output logic [AW-1:0]     o_ram_addr,
  output logic              o_ram_valid,
  output logic              o_ram_wen,
  output logic [XLEN-1:0]   o_ram_wdata,
  output logic [XLEN/8-1:0] o_ram_wstrb,
  output logic [2:0]        o_ram_size,
  input  logic              i_ram_ready,
  input  logic [XLEN-1:0]   i_ram_rdata,
  input  logic [XLEN-1:0]   i_rd_data,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_rd_wen,
  output logic [XLEN-1:0]   o_rd_data,
  output logic [4:0]        o_rd_addr,
  output logic              o_rd_wen,
  output logic [XLEN-1:0]   o_mem_rdata,
  output logic              o_mem_read,
  output logic              o_misalign,
  output logic              o_sb_empty,
  output logic              o_hold
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned EW   = $bits(sb_entry_t);

  lsu_state_e      state_q, state_d;
  logic [10:0]     info;
  logic [2:0]      size;
  logic [OFFW-1:0] off;
  logic            mis, load_req, store_req, ld_done;
  logic            sb_push, sb_pop, sb_full, sb_empty;
  logic [XLEN-1:0] wdata_sh, rdata_sh;
  logic [NB-1:0]   wstrb_sh;
  sb_entry_t       push_entry, head_entry;

  assign off        = i_mem_addr[OFFW-1:0];
  assign o_rd_data  = i_rd_data;
  assign o_rd_addr  = i_rd_addr;
  assign o_mem_read = i_mem_read;
  assign o_sb_empty = sb_empty;

  always_comb begin
    info = i_ls_info;
    if (XLEN == 32) begin
      info[LS_LD]  = 1'b0;
      info[LS_LWU] = 1'b0;
      info[LS_SD]  = 1'b0;
    end
    size = SZ_B;
    if (info[LS_LB] | info[LS_LBU] | info[LS_SB]) size = SZ_B;
    if (info[LS_LH] | info[LS_LHU] | info[LS_SH]) size = SZ_H;
    if (info[LS_LW] | info[LS_LWU] | info[LS_SW]) size = SZ_W;
    if (info[LS_LD] | info[LS_SD])                size = SZ_D;
    case (size)
      SZ_H:    mis = i_mem_addr[0];
      SZ_W:    mis = |i_mem_addr[1:0];
      SZ_D:    mis = |i_mem_addr[2:0];
      default: mis = 1'b0;
    endcase
    o_misalign = (i_mem_read | i_mem_write) & mis;
    load_req   = i_mem_read & ~mis;
    store_req  = i_mem_write & ~mis;
  end

  always_comb begin
    wdata_sh              = i_mem_wdata << {off, 3'b000};
    wstrb_sh              = NB'(size_mask(size)) << off;
    push_entry            = '0;
    push_entry.addr       = MAX_AW'(i_mem_addr);
    push_entry.wdata      = MAX_XLEN'(wdata_sh);
    push_entry.wstrb      = MAX_NB'(wstrb_sh);
    push_entry.size       = size;
    sb_push               = store_req & ~sb_full;
  end

  lsu_store_fifo #(
    .DEPTH (SB_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sb_push),
    .pop   (sb_pop),
    .din   (push_entry),
    .full  (sb_full),
    .empty (sb_empty),
    .head  (head_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sb_pop      = 1'b0;
    o_ram_valid = 1'b0;
    o_ram_wen   = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_ram_wstrb = '0;
    o_ram_size  = '0;
    unique case (state_q)
      IDLE: begin
        // A store being enqueued this cycle counts as pending so it reaches RAM next cycle.
        if (!sb_empty || sb_push) state_d = DRAIN;
        else if (load_req)        state_d = LOAD;
      end
      DRAIN: begin
        o_ram_valid = 1'b1;
        o_ram_wen   = 1'b1;
        o_ram_addr  = head_entry.addr[AW-1:0];
        o_ram_wdata = head_entry.wdata[XLEN-1:0];
        o_ram_wstrb = head_entry.wstrb[NB-1:0];
        o_ram_size  = head_entry.size;
        if (i_ram_ready) begin
          sb_pop  = 1'b1;
          state_d = IDLE;
        end
      end
      LOAD: begin
        o_ram_valid = 1'b1;
        o_ram_addr  = i_mem_addr;
        o_ram_size  = size;
        if (i_ram_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_done = (state_q == LOAD) && i_ram_ready;
    o_hold  = (load_req && !ld_done) || (store_req && sb_full);
    if (o_misalign)    o_rd_wen = 1'b0;
    else if (load_req) o_rd_wen = ld_done;
    else               o_rd_wen = i_rd_wen && !o_hold;
  end

  always_comb begin
    rdata_sh = i_ram_rdata >> {off, 3'b000};
    if (info[LS_LB])       o_mem_rdata = XLEN'($signed(rdata_sh[7:0]));
    else if (info[LS_LBU]) o_mem_rdata = XLEN'(rdata_sh[7:0]);
    else if (info[LS_LH])  o_mem_rdata = XLEN'($signed(rdata_sh[15:0]));
    else if (info[LS_LHU]) o_mem_rdata = XLEN'(rdata_sh[15:0]);
    else if (info[LS_LW])  o_mem_rdata = XLEN'($signed(rdata_sh[31:0]));
    else if (info[LS_LWU]) o_mem_rdata = XLEN'(rdata_sh[31:0]);
    else                   o_mem_rdata = rdata_sh;
  end

endmodule

// File: tb/tb_lsu_sbuf.sv
// Directed bench for lsu_sbuf: store posting, buffer-full stall, load extension,
// load ordering behind stores, misalignment and reset mid-drain.
module tb_lsu_sbuf;

  localparam int unsigned XLEN = 64;
  localparam int unsigned AW   = 64;

  localparam logic [10:0] OP_LB  = 11'h400;
  localparam logic [10:0] OP_LBU = 11'h200;
  localparam logic [10:0] OP_LD  = 11'h100;
  localparam logic [10:0] OP_LH  = 11'h080;
  localparam logic [10:0] OP_SB  = 11'h008;
  localparam logic [10:0] OP_SD  = 11'h004;
  localparam logic [10:0] OP_SW  = 11'h001;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   i_mem_addr = '0;
  logic [XLEN-1:0] i_mem_wdata = '0;
  logic [10:0]     i_ls_info = '0;
  logic            i_mem_read = 1'b0;
  logic            i_mem_write = 1'b0;
  logic            i_ram_ready = 1'b0;
  logic [XLEN-1:0] i_ram_rdata = '0;
  logic [XLEN-1:0] i_rd_data = '0;
  logic [4:0]      i_rd_addr = '0;
  logic            i_rd_wen = 1'b0;
  logic [AW-1:0]   o_ram_addr;
  logic            o_ram_valid, o_ram_wen;
  logic [XLEN-1:0] o_ram_wdata;
  logic [7:0]      o_ram_wstrb;
  logic [2:0]      o_ram_size;
  logic [XLEN-1:0] o_rd_data, o_mem_rdata;
  logic [4:0]      o_rd_addr;
  logic            o_rd_wen, o_mem_read, o_misalign, o_sb_empty, o_hold;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_sbuf #(.XLEN(XLEN), .AW(AW), .SB_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_ls_info(i_ls_info),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .o_ram_addr(o_ram_addr), .o_ram_valid(o_ram_valid), .o_ram_wen(o_ram_wen),
    .o_ram_wdata(o_ram_wdata), .o_ram_wstrb(o_ram_wstrb), .o_ram_size(o_ram_size),
    .i_ram_ready(i_ram_ready), .i_ram_rdata(i_ram_rdata),
    .i_rd_data(i_rd_data), .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
    .o_rd_data(o_rd_data), .o_rd_addr(o_rd_addr), .o_rd_wen(o_rd_wen),
    .o_mem_rdata(o_mem_rdata), .o_mem_read(o_mem_read), .o_misalign(o_misalign),
    .o_sb_empty(o_sb_empty), .o_hold(o_hold)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    samp();
    chk("rst_valid", o_ram_valid, 0);
    chk("rst_empty", o_sb_empty, 1);
    chk("rst_hold", o_hold, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // sw 0x1004: zero stall, drains next cycle in the upper lanes
    i_mem_write = 1; i_ls_info = OP_SW; i_mem_addr = 64'h1004;
    i_mem_wdata = 64'hDEADBEEF; i_rd_wen = 1;
    i_rd_data = 64'h0123_4567_89AB_CDEF; i_rd_addr = 5'd7;
    samp();
    chk("sw_hold", o_hold, 0);
    chk("sw_misalign", o_misalign, 0);
    chk("sw_valid_c0", o_ram_valid, 0);
    chk("sw_rd_wen", o_rd_wen, 1);
    chk("rd_data_pass", o_rd_data, 64'h0123_4567_89AB_CDEF);
    chk("rd_addr_pass", o_rd_addr, 7);
    chk("mem_read_pass", o_mem_read, 0);
    tick();
    i_mem_write = 0; i_ls_info = '0; i_rd_wen = 0; i_ram_ready = 1;
    samp();
    chk("sw_valid", o_ram_valid, 1);
    chk("sw_wen", o_ram_wen, 1);
    chk("sw_addr", o_ram_addr, 64'h1004);
    chk("sw_wdata", o_ram_wdata, 64'hDEADBEEF_0000_0000);
    chk("sw_wstrb", o_ram_wstrb, 8'hF0);
    chk("sw_size", o_ram_size, 2);
    tick();
    i_ram_ready = 0;
    samp();
    chk("sw_done_valid", o_ram_valid, 0);
    chk("sw_done_empty", o_sb_empty, 1);

    // lb / lbu at 0x2003 with zero-wait RAM
    tick();
    i_mem_read = 1; i_ls_info = OP_LB; i_mem_addr = 64'h2003;
    i_ram_ready = 1; i_ram_rdata = 64'h0000_0000_8000_0000;
    samp();
    chk("lb_hold_c0", o_hold, 1);
    chk("lb_valid_c0", o_ram_valid, 0);
    chk("lb_rd_wen_c0", o_rd_wen, 0);
    chk("lb_mem_read", o_mem_read, 1);
    tick();
    samp();
    chk("lb_valid", o_ram_valid, 1);
    chk("lb_wen", o_ram_wen, 0);
    chk("lb_addr", o_ram_addr, 64'h2003);
    chk("lb_wstrb", o_ram_wstrb, 0);
    chk("lb_size", o_ram_size, 0);
    chk("lb_hold_c1", o_hold, 0);
    chk("lb_rd_wen", o_rd_wen, 1);
    chk("lb_rdata", o_mem_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    i_ls_info = OP_LBU;
    samp();
    chk("lbu_hold_c0", o_hold, 1);
    tick();
    samp();
    chk("lbu_rdata", o_mem_rdata, 64'h80);
    chk("lbu_rd_wen", o_rd_wen, 1);
    tick();
    i_mem_read = 0; i_ls_info = '0; i_ram_ready = 0;

    // lh at 0x4001: misaligned, nothing happens
    i_mem_read = 1; i_ls_info = OP_LH; i_mem_addr = 64'h4001; i_rd_wen = 1;
    samp();
    chk("lh_misalign", o_misalign, 1);
    chk("lh_hold", o_hold, 0);
    chk("lh_rd_wen", o_rd_wen, 0);
    chk("lh_valid_c0", o_ram_valid, 0);
    tick();
    samp();
    chk("lh_valid_c1", o_ram_valid, 0);
    tick();
    i_mem_read = 0; i_ls_info = '0; i_rd_wen = 0;

    // sd 0x3000 then ld 0x3000: load waits for the store handshake
    i_mem_write = 1; i_ls_info = OP_SD; i_mem_addr = 64'h3000;
    i_mem_wdata = 64'h1122_3344_5566_7788; i_ram_ready = 1;
    i_ram_rdata = 64'hCAFE_BABE_0123_4567;
    samp();
    chk("sd_hold", o_hold, 0);
    tick();
    i_mem_write = 0; i_mem_read = 1; i_ls_info = OP_LD;
    samp();
    chk("sd_drain_valid", o_ram_valid, 1);
    chk("sd_drain_wen", o_ram_wen, 1);
    chk("sd_drain_wstrb", o_ram_wstrb, 8'hFF);
    chk("sd_drain_wdata", o_ram_wdata, 64'h1122_3344_5566_7788);
    chk("ld_hold_c0", o_hold, 1);
    chk("ld_rd_wen_c0", o_rd_wen, 0);
    tick();
    samp();
    chk("ld_gap_valid", o_ram_valid, 0);
    chk("ld_hold_c1", o_hold, 1);
    tick();
    samp();
    chk("ld_valid", o_ram_valid, 1);
    chk("ld_wen", o_ram_wen, 0);
    chk("ld_size", o_ram_size, 3);
    chk("ld_hold_c2", o_hold, 0);
    chk("ld_rd_wen", o_rd_wen, 1);
    chk("ld_rdata", o_mem_rdata, 64'hCAFE_BABE_0123_4567);
    tick();
    i_mem_read = 0; i_ls_info = '0; i_ram_ready = 0;

    // five back-to-back sb with RAM stalled
    for (int i = 0; i < 4; i++) begin
      i_mem_write = 1; i_ls_info = OP_SB;
      i_mem_addr = 64'h5000 + 64'(i); i_mem_wdata = 64'hA0 + 64'(i);
      samp();
      chk("sb_nostall", o_hold, 0);
      tick();
    end
    i_mem_addr = 64'h5004; i_mem_wdata = 64'hA4;
    samp();
    chk("sb5_hold", o_hold, 1);
    chk("sb5_valid", o_ram_valid, 1);
    chk("sb_head_addr", o_ram_addr, 64'h5000);
    chk("sb_head_wdata", o_ram_wdata, 64'hA0);
    chk("sb_head_wstrb", o_ram_wstrb, 8'h01);
    tick();
    samp();
    chk("sb5_hold_2", o_hold, 1);
    chk("sb_head_stable", o_ram_addr, 64'h5000);
    tick();
    i_ram_ready = 1;
    samp();
    chk("sb5_no_bypass", o_hold, 1);
    tick();
    i_ram_ready = 0;
    samp();
    chk("sb5_enqueue", o_hold, 0);
    tick();
    i_mem_write = 0; i_ls_info = '0; i_ram_ready = 1;
    samp();
    chk("sb2_valid", o_ram_valid, 1);
    chk("sb2_addr", o_ram_addr, 64'h5001);
    chk("sb2_wdata", o_ram_wdata, 64'hA100);
    chk("sb2_wstrb", o_ram_wstrb, 8'h02);
    for (int i = 0; i < 6; i++) tick();
    samp();
    chk("sb5_addr", o_ram_addr, 64'h5004);
    chk("sb5_wdata", o_ram_wdata, 64'h0000_00A4_0000_0000);
    chk("sb5_wstrb", o_ram_wstrb, 8'h10);
    tick();
    samp();
    chk("sb_all_empty", o_sb_empty, 1);
    chk("sb_all_valid", o_ram_valid, 0);
    tick();
    i_ram_ready = 0;

    // reset during DRAIN with three entries buffered
    for (int i = 0; i < 3; i++) begin
      i_mem_write = 1; i_ls_info = OP_SW;
      i_mem_addr = 64'h6000 + 64'(4 * i); i_mem_wdata = 64'h6000 + 64'(i);
      tick();
    end
    i_mem_write = 0; i_ls_info = '0;
    samp();
    chk("pre_rst_valid", o_ram_valid, 1);
    chk("pre_rst_empty", o_sb_empty, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", o_ram_valid, 0);
    chk("rst_mid_empty", o_sb_empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    samp();
    chk("post_rst_valid", o_ram_valid, 0);
    chk("post_rst_empty", o_sb_empty, 1);
    tick();
    samp();
    chk("post_rst_valid_2", o_ram_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
